// File: rtl/correlator_pkg.sv
// Shared constants for the correlator back end.
// Result words pack {imag, real} with real in the low slot.
package correlator_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int ACCUM_DEF = 24;
  localparam int PAIRS_DEF = 8;
  localparam int CBITS_DEF = 16;

  localparam int RE_SLOT = 0;
  localparam int IM_SLOT = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_e;

endpackage

// File: rtl/accum_bank.sv
// One PAIRS-entry bank of {imag, real} accumulators.
// Write port either overwrites or adds into the addressed entry.
module accum_bank
  import correlator_pkg::*;
#(
  parameter int PAIRS = PAIRS_DEF,
  parameter int ACCUM = ACCUM_DEF,
  localparam int ABITS = $clog2(PAIRS),
  localparam int DW = 2 * ACCUM
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic             add_i,
  input  logic [ABITS-1:0] acc_addr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [ABITS-1:0] rd_addr_i,
  output logic [DW-1:0]    rd_data_o
);

  logic [DW-1:0]    mem_q [PAIRS];
  logic [DW-1:0]    acc_q;
  logic [DW-1:0]    wr_d;
  logic [ACCUM-1:0] sum_re;
  logic [ACCUM-1:0] sum_im;

  // Read ports and the modulo-2^ACCUM add path.
  always_comb begin
    acc_q     = mem_q[acc_addr_i];
    rd_data_o = mem_q[rd_addr_i];
    sum_re = acc_q[RE_SLOT*ACCUM +: ACCUM]
           + wdata_i[RE_SLOT*ACCUM +: ACCUM];
    sum_im = acc_q[IM_SLOT*ACCUM +: ACCUM]
           + wdata_i[IM_SLOT*ACCUM +: ACCUM];
    wr_d = wdata_i;
    if (add_i) begin
      wr_d[RE_SLOT*ACCUM +: ACCUM] = sum_re;
      wr_d[IM_SLOT*ACCUM +: ACCUM] = sum_im;
    end
  end

  // Single-cycle read-modify-write; storage is not reset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[acc_addr_i] <= wr_d;
  end

endmodule

// File: rtl/visibility_accumulate.sv
// Integrates correlator partial sums over N frames into two
// ping-pong banks and streams the finished bank out.
module visibility_accumulate
  import correlator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACCUM = ACCUM_DEF,
  parameter int PAIRS = PAIRS_DEF,
  parameter int CBITS = CBITS_DEF,
  localparam int ABITS = $clog2(PAIRS),
  localparam int DW = 2 * ACCUM
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CBITS-1:0] count_i,
  input  logic             frame_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [WIDTH-1:0] idata_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [DW-1:0]    m_tdata,
  output logic             overflow_o,
  output logic             frame_err_o
);

  localparam logic [ABITS:0] IDX_ONE = (ABITS+1)'(1);
  localparam logic [ABITS:0] IDX_FULL = (ABITS+1)'(PAIRS);
  localparam logic [ABITS-1:0] BEAT_ONE = ABITS'(1);
  localparam logic [ABITS-1:0] BEAT_LAST = ABITS'(PAIRS-1);
  localparam logic [CBITS-1:0] CNT_ONE = CBITS'(1);

  rd_state_e        state_q, state_d;
  logic             frame_q, frame_d;
  logic [ABITS:0]   idx_q, idx_d;
  logic [CBITS-1:0] fcnt_q, fcnt_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             wsel_q, wsel_d;
  logic [ABITS-1:0] beat_q, beat_d;
  logic             ovf_q, ovf_d;
  logic             ferr_q, ferr_d;

  logic             acc_v;
  logic             in_rng;
  logic             wr_en;
  logic             first;
  logic             fend;
  logic             iend;
  logic             hs;
  logic             last;
  logic             idle;
  logic [CBITS-1:0] cnt_eff;
  logic [DW-1:0]    wdata;
  logic [DW-1:0]    rd0;
  logic [DW-1:0]    rd1;

  // Zero-extend the partial sums into a packed result word.
  always_comb begin
    wdata = '0;
    wdata[RE_SLOT*ACCUM +: ACCUM] = ACCUM'(rdata_i);
    wdata[IM_SLOT*ACCUM +: ACCUM] = ACCUM'(idata_i);
  end

  // Decode of frame, integration and handshake events.
  always_comb begin
    acc_v   = frame_i & valid_i;
    in_rng  = ~idx_q[ABITS];
    wr_en   = acc_v & in_rng;
    first   = (fcnt_q == '0);
    fend    = frame_q & ~frame_i;
    cnt_eff = (count_q == '0) ? CNT_ONE : count_q;
    iend    = fend & (fcnt_q == cnt_eff - CNT_ONE);
    hs      = (state_q == RD_BUSY) & m_tready;
    last    = (beat_q == BEAT_LAST);
    idle    = (state_q == RD_IDLE) | (hs & last);
  end

  // Next-state logic for accumulation and readout control.
  always_comb begin
    state_d = state_q;
    frame_d = frame_i;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    count_d = count_q;
    wsel_d  = wsel_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q;
    if (acc_v) begin
      if (in_rng) idx_d = idx_q + IDX_ONE;
      else ferr_d = 1'b1;
      if (first && idx_q == '0) count_d = count_i;
    end
    if (fend) begin
      idx_d = '0;
      if (idx_q != IDX_FULL) ferr_d = 1'b1;
      fcnt_d = iend ? '0 : fcnt_q + CNT_ONE;
    end
    if (hs) begin
      if (last) state_d = RD_IDLE;
      else beat_d = beat_q + BEAT_ONE;
    end
    if (iend) begin
      if (idle) begin
        wsel_d  = ~wsel_q;
        state_d = RD_BUSY;
        beat_d  = '0;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RD_IDLE;
      frame_q <= 1'b0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      count_q <= '0;
      wsel_q  <= 1'b0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      count_q <= count_d;
      wsel_q  <= wsel_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  accum_bank #(.PAIRS(PAIRS), .ACCUM(ACCUM)) u_bank0 (
    .clock      (clock),
    .we_i       (wr_en & ~wsel_q),
    .add_i      (~first),
    .acc_addr_i (idx_q[ABITS-1:0]),
    .wdata_i    (wdata),
    .rd_addr_i  (beat_q),
    .rd_data_o  (rd0)
  );

  accum_bank #(.PAIRS(PAIRS), .ACCUM(ACCUM)) u_bank1 (
    .clock      (clock),
    .we_i       (wr_en & wsel_q),
    .add_i      (~first),
    .acc_addr_i (idx_q[ABITS-1:0]),
    .wdata_i    (wdata),
    .rd_addr_i  (beat_q),
    .rd_data_o  (rd1)
  );

  // Readout always drains the bank not being written.
  always_comb begin
    m_tvalid    = (state_q == RD_BUSY);
    m_tlast     = (state_q == RD_BUSY) & last;
    m_tdata     = wsel_q ? rd0 : rd1;
    overflow_o  = ovf_q;
    frame_err_o = ferr_q;
  end

endmodule

// File: doc/visibility_accumulate.md
Name: visibility_accumulate

Overview:
- Sits directly downstream of the 1-bit correlator. It consumes the correlator's short per-block partial sums (valid, real, imag, frame) and integrates them into wide per-pair accumulators over a configurable number of frames.
- It double-buffers the results. The completed integration is emitted as an AXI4-Stream with backpressure while the next integration proceeds in the other bank.

Parameters:
- WIDTH, 4, bit-width of input partial sums (matches correlator WIDTH).
- ACCUM, 24, bit-width of each real/imag accumulator.
- PAIRS, 8, correlation results per frame (time-multiplexed pairs); power of two.
- ABITS, log2(PAIRS), pair index width (localparam).
- CBITS, 16, width of the frame-count configuration.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- count_i  input  CBITS  frames per integration; sampled at the start of each integration; 0 treated as 1.
- frame_i  input  1  frame envelope from the correlator.
- valid_i  input  1  partial-sum strobe; ignored when frame_i=0.
- rdata_i  input  WIDTH  unsigned real partial sum.
- idata_i  input  WIDTH  unsigned imag partial sum.
- m_tvalid  output  1  result beat valid.
- m_tready  input  1  downstream ready.
- m_tlast  output  1  last beat (pair PAIRS-1).
- m_tdata  output  2*ACCUM  {imag, real} accumulator, unsigned.
- overflow_o  output  1  sticky: an integration completed while the previous readout was still in progress.
- frame_err_o  output  1  sticky: a frame delivered a valid count other than PAIRS.

Behaviour:
- Reset values: m_tvalid=0, m_tlast=0, overflow_o=0, frame_err_o=0, write-bank select=0, pair index=0, frame counter=0, readout idle.
- Reset mid-readout aborts the readout; m_tvalid is low the cycle after reset is asserted.
- Accumulator storage is not reset.
- Pair index:
  - Increments on each valid_i while frame_i=1.
  - Entry written = current index.
  - Valids beyond index PAIRS-1 in one frame are dropped and set frame_err_o.
- Frame end is detected when frame_q=1 and frame_i=0 (frame_q is frame_i registered once). At frame end:
  - If the index is not equal to PAIRS, frame_err_o is set.
  - The index returns to 0.
  - The frame counter increments.
- Accumulate:
  - Inputs are zero-extended to ACCUM bits.
  - If frame counter=0 (first frame of an integration), the entry is overwritten with the input.
  - Otherwise entry <= entry + input, modulo 2^ACCUM, with no saturation.
  - The read-modify-write completes in one cycle, so back-to-back valids to successive indices are supported at full rate.
- count_i is latched into count_q on the first valid of frame 0.
- Integration end: at the frame end where frame counter = count_q-1.
  - The frame counter clears.
  - If the readout is idle: the write-bank select toggles, and the readout starts on the just-completed bank. m_tvalid rises the next cycle.
  - If the readout is busy: the completed bank is discarded, overflow_o is set, and the bank select does not toggle. The next integration overwrites the same bank via first-frame semantics. The in-progress readout continues undisturbed.
- Readout:
  - Beat k (k=0..PAIRS-1) presents bank[k] in m_tdata.
  - The beat advances only when m_tvalid & m_tready.
  - m_tlast=1 on k=PAIRS-1; after that handshake m_tvalid drops and the readout goes idle.
  - m_tdata and m_tlast hold stable while m_tvalid=1 and m_tready=0.
- The integration-end swap and a final readout handshake in the same cycle count as idle, so the swap proceeds.
- No input backpressure; input is never stalled.

Decomposition:
- Shared package (correlator_pkg): the WIDTH/ACCUM defaults and the {imag, real} result-word packing helper/constants.
- Natural sub-module: accum_bank. It holds one PAIRS x 2*ACCUM register bank and provides:
  - one combinational read port for the accumulate path;
  - one combinational read port for readout;
  - one write port with overwrite/add select.
- The top level instantiates two accum_bank instances plus control.

Test Plan:
- count_i=1, one frame of 8 valids with r=i+1, i=2 (i=0..7), m_tready=1 -> 8 beats, real=1..8, imag=2, m_tlast on beat 7, first m_tvalid one cycle after frame end.
- count_i=3, three identical frames, all r=2, i=1 -> every beat real=6, imag=3; a second integration then restarts from the overwrite (real=6, not 12).
- ACCUM=4, count_i=10, r=2 each frame -> real wraps to 20 mod 16 = 4; no flags set.
- Integration ends while m_tready is held 0 mid-readout -> overflow_o=1; the old beats complete with unchanged data once ready returns; the discarded bank is never emitted.
- A frame with 7 valids, then a frame with 9 valids -> frame_err_o=1 after the first; the 9th valid is dropped and entry 7 holds only its earlier value.
- Reset asserted during beat 3 -> m_tvalid=0 next cycle; the next integration streams correctly with bank select 0.
